// File: rtl/idex_register.sv
// ID/EX pipeline register: captures the decoded instruction for the Execute stage.
// A synchronous reset clears the stage. A flush replaces it with a NOP whose PCs carry FLUSH_PC.
module idex_register #(
  parameter logic [31:0] FLUSH_PC = 32'h2A2A_2A2A
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Flush_E,
  input  logic        REG_W_En_D,
  input  logic        MEM_W_En_D,
  input  logic        Jump_En_D,
  input  logic        Branch_En_D,
  input  logic [2:0]  MEM_Control_D,
  input  logic [3:0]  ALU_Control_D,
  input  logic        Branch_Src_Sel_D,
  input  logic        ALU_SrcA_Sel_D,
  input  logic        ALU_SrcB_Sel_D,
  input  logic [1:0]  Result_Src_Sel_D,
  input  logic [4:0]  RD_D,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [31:0] REG_R_Data1_D,
  input  logic [31:0] REG_R_Data2_D,
  input  logic [31:0] Imm_Ext_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] PC_Plus_4_D,
  output logic        REG_W_En_E,
  output logic        MEM_W_En_E,
  output logic        Jump_En_E,
  output logic        Branch_En_E,
  output logic [2:0]  MEM_Control_E,
  output logic [3:0]  ALU_Control_E,
  output logic        Branch_Src_Sel_E,
  output logic        ALU_SrcA_Sel_E,
  output logic        ALU_SrcB_Sel_E,
  output logic [1:0]  Result_Src_Sel_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] REG_R_Data1_E,
  output logic [31:0] REG_R_Data2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [31:0] PC_E,
  output logic [31:0] PC_Plus_4_E
);

  typedef struct packed {
    logic        reg_w_en;
    logic        mem_w_en;
    logic        jump_en;
    logic        branch_en;
    logic [2:0]  mem_control;
    logic [3:0]  alu_control;
    logic        branch_src_sel;
    logic        alu_srca_sel;
    logic        alu_srcb_sel;
    logic [1:0]  result_src_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg_r_data1;
    logic [31:0] reg_r_data2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;
  stage_t nop_stage;

  always_comb begin
    stage_d                = '0;
    stage_d.reg_w_en       = REG_W_En_D;
    stage_d.mem_w_en       = MEM_W_En_D;
    stage_d.jump_en        = Jump_En_D;
    stage_d.branch_en      = Branch_En_D;
    stage_d.mem_control    = MEM_Control_D;
    stage_d.alu_control    = ALU_Control_D;
    stage_d.branch_src_sel = Branch_Src_Sel_D;
    stage_d.alu_srca_sel   = ALU_SrcA_Sel_D;
    stage_d.alu_srcb_sel   = ALU_SrcB_Sel_D;
    stage_d.result_src_sel = Result_Src_Sel_D;
    stage_d.rd             = RD_D;
    stage_d.rs1            = RS1_D;
    stage_d.rs2            = RS2_D;
    stage_d.reg_r_data1    = REG_R_Data1_D;
    stage_d.reg_r_data2    = REG_R_Data2_D;
    stage_d.imm_ext        = Imm_Ext_D;
    stage_d.pc             = PC_D;
    stage_d.pc_plus_4      = PC_Plus_4_D;
  end

  // The flushed NOP keeps a recognisable PC marker so it stands out in traces.
  always_comb begin
    nop_stage           = '0;
    nop_stage.pc        = FLUSH_PC;
    nop_stage.pc_plus_4 = FLUSH_PC;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_q <= '0;
    end else if (Flush_E) begin
      stage_q <= nop_stage;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign REG_W_En_E       = stage_q.reg_w_en;
  assign MEM_W_En_E       = stage_q.mem_w_en;
  assign Jump_En_E        = stage_q.jump_en;
  assign Branch_En_E      = stage_q.branch_en;
  assign MEM_Control_E    = stage_q.mem_control;
  assign ALU_Control_E    = stage_q.alu_control;
  assign Branch_Src_Sel_E = stage_q.branch_src_sel;
  assign ALU_SrcA_Sel_E   = stage_q.alu_srca_sel;
  assign ALU_SrcB_Sel_E   = stage_q.alu_srcb_sel;
  assign Result_Src_Sel_E = stage_q.result_src_sel;
  assign RD_E             = stage_q.rd;
  assign RS1_E            = stage_q.rs1;
  assign RS2_E            = stage_q.rs2;
  assign REG_R_Data1_E    = stage_q.reg_r_data1;
  assign REG_R_Data2_E    = stage_q.reg_r_data2;
  assign Imm_Ext_E        = stage_q.imm_ext;
  assign PC_E             = stage_q.pc;
  assign PC_Plus_4_E      = stage_q.pc_plus_4;

endmodule

// File: tb/tb_idex_register.sv
// Bench for idex_register: random and directed decode bundles are checked against an
// expected queue filled by a rule-level model of reset, flush and pass-through.
module tb_idex_register;

  localparam logic [31:0] MARKER = 32'h2A2A_2A2A;

  typedef struct packed {
    logic        reg_w_en;
    logic        mem_w_en;
    logic        jump_en;
    logic        branch_en;
    logic [2:0]  mem_control;
    logic [3:0]  alu_control;
    logic        branch_src_sel;
    logic        alu_srca_sel;
    logic        alu_srcb_sel;
    logic [1:0]  result_src_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg_r_data1;
    logic [31:0] reg_r_data2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } stage_t;

  logic        CLK;
  logic        RST;
  logic        Flush_E;
  logic        REG_W_En_D, MEM_W_En_D, Jump_En_D, Branch_En_D;
  logic [2:0]  MEM_Control_D;
  logic [3:0]  ALU_Control_D;
  logic        Branch_Src_Sel_D, ALU_SrcA_Sel_D, ALU_SrcB_Sel_D;
  logic [1:0]  Result_Src_Sel_D;
  logic [4:0]  RD_D, RS1_D, RS2_D;
  logic [31:0] REG_R_Data1_D, REG_R_Data2_D, Imm_Ext_D, PC_D, PC_Plus_4_D;
  logic        REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E;
  logic [2:0]  MEM_Control_E;
  logic [3:0]  ALU_Control_E;
  logic        Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E;
  logic [1:0]  Result_Src_Sel_E;
  logic [4:0]  RD_E, RS1_E, RS2_E;
  logic [31:0] REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E, PC_E, PC_Plus_4_E;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [$bits(stage_t)-1:0] exp_q[$];

  idex_register dut (
    .CLK(CLK), .RST(RST), .Flush_E(Flush_E),
    .REG_W_En_D(REG_W_En_D), .MEM_W_En_D(MEM_W_En_D),
    .Jump_En_D(Jump_En_D), .Branch_En_D(Branch_En_D),
    .MEM_Control_D(MEM_Control_D), .ALU_Control_D(ALU_Control_D),
    .Branch_Src_Sel_D(Branch_Src_Sel_D), .ALU_SrcA_Sel_D(ALU_SrcA_Sel_D),
    .ALU_SrcB_Sel_D(ALU_SrcB_Sel_D), .Result_Src_Sel_D(Result_Src_Sel_D),
    .RD_D(RD_D), .RS1_D(RS1_D), .RS2_D(RS2_D),
    .REG_R_Data1_D(REG_R_Data1_D), .REG_R_Data2_D(REG_R_Data2_D),
    .Imm_Ext_D(Imm_Ext_D), .PC_D(PC_D), .PC_Plus_4_D(PC_Plus_4_D),
    .REG_W_En_E(REG_W_En_E), .MEM_W_En_E(MEM_W_En_E),
    .Jump_En_E(Jump_En_E), .Branch_En_E(Branch_En_E),
    .MEM_Control_E(MEM_Control_E), .ALU_Control_E(ALU_Control_E),
    .Branch_Src_Sel_E(Branch_Src_Sel_E), .ALU_SrcA_Sel_E(ALU_SrcA_Sel_E),
    .ALU_SrcB_Sel_E(ALU_SrcB_Sel_E), .Result_Src_Sel_E(Result_Src_Sel_E),
    .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .REG_R_Data1_E(REG_R_Data1_E), .REG_R_Data2_E(REG_R_Data2_E),
    .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PC_Plus_4_E(PC_Plus_4_E)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic stage_t rand_stage();
    stage_t s;
    s.reg_w_en       = 1'($urandom_range(0, 1));
    s.mem_w_en       = 1'($urandom_range(0, 1));
    s.jump_en        = 1'($urandom_range(0, 1));
    s.branch_en      = 1'($urandom_range(0, 1));
    s.mem_control    = 3'($urandom_range(0, 7));
    s.alu_control    = 4'($urandom_range(0, 15));
    s.branch_src_sel = 1'($urandom_range(0, 1));
    s.alu_srca_sel   = 1'($urandom_range(0, 1));
    s.alu_srcb_sel   = 1'($urandom_range(0, 1));
    s.result_src_sel = 2'($urandom_range(0, 3));
    s.rd             = 5'($urandom_range(0, 31));
    s.rs1            = 5'($urandom_range(0, 31));
    s.rs2            = 5'($urandom_range(0, 31));
    s.reg_r_data1    = $urandom;
    s.reg_r_data2    = $urandom;
    s.imm_ext        = $urandom;
    s.pc             = $urandom;
    s.pc_plus_4      = $urandom;
    return s;
  endfunction

  // Reference model: what the Execute stage must hold after an edge with these inputs.
  function automatic stage_t model(input logic rst, input logic flush, input stage_t d);
    stage_t r;
    if (rst) begin
      r = '0;
    end else if (flush) begin
      r = '0;
      r.pc = MARKER;
      r.pc_plus_4 = MARKER;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic stage_t observe();
    stage_t o;
    o = '{REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E, MEM_Control_E, ALU_Control_E,
          Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E, Result_Src_Sel_E,
          RD_E, RS1_E, RS2_E, REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E, PC_E, PC_Plus_4_E};
    return o;
  endfunction

  // Driver tasks
  task automatic apply(input stage_t s, input logic rst, input logic flush);
    RST              = rst;
    Flush_E          = flush;
    REG_W_En_D       = s.reg_w_en;
    MEM_W_En_D       = s.mem_w_en;
    Jump_En_D        = s.jump_en;
    Branch_En_D      = s.branch_en;
    MEM_Control_D    = s.mem_control;
    ALU_Control_D    = s.alu_control;
    Branch_Src_Sel_D = s.branch_src_sel;
    ALU_SrcA_Sel_D   = s.alu_srca_sel;
    ALU_SrcB_Sel_D   = s.alu_srcb_sel;
    Result_Src_Sel_D = s.result_src_sel;
    RD_D             = s.rd;
    RS1_D            = s.rs1;
    RS2_D            = s.rs2;
    REG_R_Data1_D    = s.reg_r_data1;
    REG_R_Data2_D    = s.reg_r_data2;
    Imm_Ext_D        = s.imm_ext;
    PC_D             = s.pc;
    PC_Plus_4_D      = s.pc_plus_4;
    exp_q.push_back(model(rst, flush, s));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    stage_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      apply(rand_stage(), 1'b0, 1'($urandom_range(0, 1)));
      tick();
      void'(exp_q.pop_front());
    end
    apply(rand_stage(), 1'b1, 1'b0);
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_after_traffic: got %h want %h", obs, exp);
    end
    n_cmp++;
    if ({REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_enables: got %b want 0000",
               {REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E});
    end
  endtask

  task automatic test_pass_through();
    stage_t s, obs, exp;
    s = rand_stage();
    s.rd          = 5'h1F;
    s.reg_r_data1 = 32'hDEADBEEF;
    s.pc          = 32'h100;
    s.pc_plus_4   = 32'h104;
    s.alu_control = 4'hA;
    apply(s, 1'b0, 1'b0);
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pass_through: got %h want %h", obs, exp);
    end
    n_cmp++;
    if ({RD_E, REG_R_Data1_E, PC_E, PC_Plus_4_E, ALU_Control_E} !==
        {5'h1F, 32'hDEADBEEF, 32'h100, 32'h104, 4'hA}) begin
      n_fail++;
      $display("FAIL pass_through_fields: got %h %h %h %h %h want 1f deadbeef 100 104 a",
               RD_E, REG_R_Data1_E, PC_E, PC_Plus_4_E, ALU_Control_E);
    end
  endtask

  task automatic test_flush_and_recovery();
    stage_t s, obs, exp;
    s = rand_stage();
    {s.reg_w_en, s.mem_w_en, s.jump_en, s.branch_en} = 4'b1111;
    s.pc = 32'h200;
    apply(s, 1'b0, 1'b1);
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL flush: got %h want %h", obs, exp);
    end
    n_cmp++;
    if (PC_E !== 32'h2A2A2A2A || PC_Plus_4_E !== 32'h2A2A2A2A) begin
      n_fail++;
      $display("FAIL flush_pc: got %h/%h want 2a2a2a2a", PC_E, PC_Plus_4_E);
    end
    apply(rand_stage(), 1'b0, 1'b0);
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL flush_recovery: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_priority();
    stage_t obs, exp;
    apply(rand_stage(), 1'b1, 1'b1);
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_over_flush: got %h want %h", obs, exp);
    end
    n_cmp++;
    if (PC_E !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_over_flush_pc: got %h want 00000000", PC_E);
    end
  endtask

  // A reset pulse that starts and ends between edges must leave the load untouched.
  task automatic test_sync_reset();
    stage_t obs, exp;
    apply(rand_stage(), 1'b0, 1'b0);
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL glitch_reset_ignored: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_random();
    stage_t obs, exp;
    for (int i = 0; i < 60; i++) begin
      apply(rand_stage(), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 4) == 0));
      tick();
      obs = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    stage_t obs, exp;
    for (int i = 0; i < 8; i++) begin
      apply(rand_stage(), 1'b0, 1'(i % 2));
      tick();
      obs = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    stage_t obs, exp;
    apply(rand_stage(), 1'b1, 1'b0);
    tick();
    obs = observe();
    exp = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL initial_reset: got %h want %h", obs, exp);
    end
    test_reset();
    test_pass_through();
    test_flush_and_recovery();
    test_priority();
    test_sync_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/idex_register.md
IDEX_REGISTER -- requirements
Module: idex_register

Interface
REQ-001 Parameter FLUSH_PC, default 32'h2A2A_2A2A, PC marker value loaded into PC_E and PC_Plus_4_E on flush.
REQ-002 The block SHALL have one clock (CLK); reset is synchronous and active-high (RST).
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 Flush_E  in  1  synchronous flush; inserts NOP into Execute stage.
REQ-006 REG_W_En_D in 1 / REG_W_En_E out 1  register-file write enable.
REQ-007 MEM_W_En_D in 1 / MEM_W_En_E out 1  data-memory write enable.
REQ-008 Jump_En_D in 1 / Jump_En_E out 1  jump enable.
REQ-009 Branch_En_D in 1 / Branch_En_E out 1  branch enable.
REQ-010 MEM_Control_D in 3 / MEM_Control_E out 3  load/store width and sign control.
REQ-011 ALU_Control_D in 4 / ALU_Control_E out 4  ALU operation select.
REQ-012 Branch_Src_Sel_D in 1 / Branch_Src_Sel_E out 1  branch target source select.
REQ-013 ALU_SrcA_Sel_D in 1 / ALU_SrcA_Sel_E out 1  ALU operand A select.
REQ-014 ALU_SrcB_Sel_D in 1 / ALU_SrcB_Sel_E out 1  ALU operand B select.
REQ-015 Result_Src_Sel_D in 2 / Result_Src_Sel_E out 2  writeback result select.
REQ-016 RD_D, RS1_D, RS2_D in 5 each / RD_E, RS1_E, RS2_E out 5 each  register indices.
REQ-017 REG_R_Data1_D, REG_R_Data2_D in 32 / REG_R_Data1_E, REG_R_Data2_E out 32  register read data.
REQ-018 Imm_Ext_D in 32 / Imm_Ext_E out 32  sign-extended immediate.
REQ-019 PC_D, PC_Plus_4_D in 32 / PC_E, PC_Plus_4_E out 32  instruction PC and PC+4.

Function
REQ-020 All outputs SHALL be registered (driven directly from flops), with no combinational path from any input to any output.
REQ-021 Priority each rising CLK edge: RST, then Flush_E, then normal load.
REQ-022 Normal (RST=0, Flush_E=0): every _E output SHALL equal its _D input sampled at that edge (latency 1 cycle, no stall/enable input).
REQ-023 Flush (RST=0, Flush_E=1): REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E SHALL be 0.
REQ-024 Flush: PC_E = PC_Plus_4_E = FLUSH_PC.
REQ-025 Flush: all other _E outputs SHALL be 0.
REQ-026 Flush lasts one cycle per asserted edge; normal loading resumes on the next edge with Flush_E=0.
REQ-027 Simultaneous RST and Flush_E: reset behaviour applies.
REQ-028 Inputs are captured as-is; no decoding or width conversion.

Reset
REQ-029 On a rising edge with RST=1, all _E outputs SHALL be 0, including PC_E and PC_Plus_4_E.
REQ-030 Reset SHALL be synchronous; RST asserted between edges has no effect until the next rising edge.
REQ-031 Output values before the first reset edge are unspecified.

Verification
REQ-032 Reset: RST=1 for one edge after random traffic -> next cycle all four enables = 0 and all other outputs = 0.
REQ-033 Pass-through: RST=0, Flush_E=0, RD_D=5'h1F, REG_R_Data1_D=32'hDEADBEEF, PC_D=32'h100, PC_Plus_4_D=32'h104, ALU_Control_D=4'hA -> one edge later the same values on the _E outputs.
REQ-034 Flush: Flush_E=1 with all enables=1 on the _D inputs and PC_D=32'h200 -> next cycle enables = 0, PC_E = PC_Plus_4_E = 32'h2A2A2A2A, other outputs 0.
REQ-035 Flush recovery: Flush_E deasserted after one cycle -> next edge outputs equal the current _D inputs.
REQ-036 Priority: RST=1 and Flush_E=1 together -> PC_E = 0, not 32'h2A2A2A2A.
REQ-037 Random: at least 5 cycles of $urandom stimulus across all inputs -> every _E output equals the previous cycle's _D input each cycle.
